// File: rtl/dsi_pkg.sv
// rtl/dsi_pkg.sv - shared DSI lane constants, rx state encoding and small helpers.
package dsi_pkg;

    // Sync byte is shared with the tx lane.
    localparam logic [7:0] SYNC_SEQUENCE = 8'b00011101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        HUNT   = 3'd2,
        ACTIVE = 3'd3,
        ERR    = 3'd4
    } rx_state_t;

    function automatic logic sync_match(input logic [7:0] cand, input logic tol);
        int ones;
        ones = $countones(cand ^ SYNC_SEQUENCE);
        return tol ? (ones <= 1) : (ones == 0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dsi_hs_byte_aligner.sv
// rtl/dsi_hs_byte_aligner.sv - two-byte lane window, sync search, offset latch and barrel select.
module dsi_hs_byte_aligner #(
    parameter int SYNC_ERR_TOL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hs_input,
    input  logic       hunt,
    output logic       match,
    output logic [7:0] sel_byte
);
    import dsi_pkg::*;

    logic [7:0]  prev_byte;
    logic [2:0]  offset;
    logic [2:0]  match_k;
    logic [15:0] window;

    // Older byte sits in the low half so window bit 0 is the earliest bit on the wire.
    assign window = {hs_input, prev_byte};

    // Descending scan so the lowest matching bit position is the one left standing.
    always_comb begin
        match   = 1'b0;
        match_k = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (sync_match(window[k +: 8], SYNC_ERR_TOL != 0)) begin
                match   = 1'b1;
                match_k = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_byte <= 8'd0;
            offset    <= 3'd0;
        end else begin
            prev_byte <= hs_input;
            if (hunt && match) begin
                offset <= match_k;
            end
        end
    end

    assign sel_byte = window[offset +: 8];

endmodule

// File: rtl/dsi_hs_lane_rx.sv
// rtl/dsi_hs_lane_rx.sv - DSI high-speed lane receiver: settle, sync hunt and aligned byte output.
module dsi_hs_lane_rx #(
    parameter int SYNC_ERR_TOL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hs_input,
    input  logic       hs_valid,
    input  logic [7:0] hs_settle_timeout,
    input  logic [7:0] hs_sync_timeout,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_start,
    output logic       out_end,
    output logic       active,
    output logic       sync_err
);
    import dsi_pkg::*;

    rx_state_t  state;
    logic [7:0] settle_cnt;
    logic [7:0] hunt_cnt;
    logic       lp_seen;
    logic       first_byte;
    logic       align_match;
    logic [7:0] align_byte;
    logic       hunting;
    logic       settle_done;
    logic       hunt_expired;

    dsi_hs_byte_aligner #(
        .SYNC_ERR_TOL (SYNC_ERR_TOL)
    ) u_aligner (
        .clk      (clk),
        .rst      (rst),
        .hs_input (hs_input),
        .hunt     (hunting),
        .match    (align_match),
        .sel_byte (align_byte)
    );

    assign hunting = (state == HUNT) && hs_valid;

    // Widened compares keep a zero or shrinking timeout from underflowing.
    assign settle_done  = ({1'b0, settle_cnt} + 9'd1) >= {1'b0, hs_settle_timeout};
    assign hunt_expired = (hs_sync_timeout != 8'd0) &&
                          (({1'b0, hunt_cnt} + 9'd1) >= {1'b0, hs_sync_timeout});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            hunt_cnt   <= 8'd0;
            lp_seen    <= 1'b0;
            first_byte <= 1'b0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_start  <= 1'b0;
            out_end    <= 1'b0;
            active     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_end   <= 1'b0;
            sync_err  <= 1'b0;
            if (!hs_valid) begin
                // A burst already running at reset release is ignored until LP is seen.
                lp_seen    <= 1'b1;
                out_end    <= (state == ACTIVE);
                state      <= IDLE;
                active     <= 1'b0;
                settle_cnt <= 8'd0;
                hunt_cnt   <= 8'd0;
                first_byte <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (lp_seen) begin
                            active     <= 1'b1;
                            settle_cnt <= 8'd0;
                            hunt_cnt   <= 8'd0;
                            if (hs_settle_timeout == 8'd0) begin
                                state <= HUNT;
                            end else begin
                                state <= SETTLE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (settle_done) begin
                            state    <= HUNT;
                            hunt_cnt <= 8'd0;
                        end else begin
                            settle_cnt <= sat_inc(settle_cnt);
                        end
                    end
                    HUNT: begin
                        if (align_match) begin
                            state      <= ACTIVE;
                            first_byte <= 1'b1;
                        end else if (hunt_expired) begin
                            state    <= ERR;
                            sync_err <= 1'b1;
                        end else begin
                            hunt_cnt <= sat_inc(hunt_cnt);
                        end
                    end
                    ACTIVE: begin
                        out_valid  <= 1'b1;
                        out_data   <= align_byte;
                        out_start  <= first_byte;
                        first_byte <= 1'b0;
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// tb/tb_dsi_hs_lane_rx.sv - scoreboard bench for dsi_hs_lane_rx, exact-match and tolerant instances.
module tb_dsi_hs_lane_rx;

    typedef struct packed {
        logic       valid;
        logic       start;
        logic [7:0] data;
        logic       fin;
        logic       err;
    } evt_t;

    typedef struct {
        int          cyc;
        int          dut;
        string       name;
        logic [15:0] exp;
        logic [15:0] mask;
    } probe_t;

    // Probe word: {offset[2:0], active, sync_err, out_end, out_start, out_valid, out_data}
    localparam logic [15:0] M_ALL  = 16'hFFFF;
    localparam logic [15:0] M_CTRL = 16'h1F00;
    localparam logic [15:0] M_OUTS = 16'h1FFF;
    localparam logic [15:0] M_OFF  = 16'hE000;
    localparam logic [15:0] B_ACT  = 16'h1000;
    localparam logic [15:0] B_ERR  = 16'h0800;
    localparam logic [15:0] B_END  = 16'h0400;
    localparam logic [15:0] B_STA  = 16'h0200;
    localparam logic [15:0] B_VAL  = 16'h0100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hs_input;
    logic       hs_valid;
    logic [7:0] settle;
    logic [7:0] synct;

    logic [7:0] out_data0, out_data1;
    logic       out_valid0, out_valid1, out_start0, out_start1;
    logic       out_end0, out_end1, active0, active1, sync_err0, sync_err1;

    evt_t   q0[$];
    evt_t   q1[$];
    probe_t pq[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    bit     done = 1'b0;

    evt_t        o0, o1;
    probe_t      p;
    logic [15:0] w0, w1, wsel;

    always #5 clk = ~clk;

    dsi_hs_lane_rx #(.SYNC_ERR_TOL(0)) dut0 (
        .clk(clk), .rst(rst), .hs_input(hs_input), .hs_valid(hs_valid),
        .hs_settle_timeout(settle), .hs_sync_timeout(synct),
        .out_data(out_data0), .out_valid(out_valid0), .out_start(out_start0),
        .out_end(out_end0), .active(active0), .sync_err(sync_err0)
    );

    dsi_hs_lane_rx #(.SYNC_ERR_TOL(1)) dut1 (
        .clk(clk), .rst(rst), .hs_input(hs_input), .hs_valid(hs_valid),
        .hs_settle_timeout(settle), .hs_sync_timeout(synct),
        .out_data(out_data1), .out_valid(out_valid1), .out_start(out_start1),
        .out_end(out_end1), .active(active1), .sync_err(sync_err1)
    );

    function automatic evt_t ev_data(input logic s, input logic [7:0] d);
        evt_t e;
        e = '{valid: 1'b1, start: s, data: d, fin: 1'b0, err: 1'b0};
        return e;
    endfunction

    function automatic evt_t ev_end();
        evt_t e;
        e = '{valid: 1'b0, start: 1'b0, data: 8'h00, fin: 1'b1, err: 1'b0};
        return e;
    endfunction

    function automatic evt_t ev_err();
        evt_t e;
        e = '{valid: 1'b0, start: 1'b0, data: 8'h00, fin: 1'b0, err: 1'b1};
        return e;
    endfunction

    task automatic exp_both(input evt_t e);
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic probe(input int which, input string nm, input logic [15:0] e, input logic [15:0] m);
        probe_t np;
        np.cyc  = cyc;
        np.dut  = which;
        np.name = nm;
        np.exp  = e;
        np.mask = m;
        pq.push_back(np);
    endtask

    task automatic probe_both(input string nm, input logic [15:0] e, input logic [15:0] m);
        probe(0, nm, e, m);
        probe(1, nm, e, m);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        hs_valid = v;
        hs_input = d;
        @(posedge clk);
        #1;
    endtask

    task automatic mon_evt(input int which, input evt_t obs);
        evt_t e;
        if (obs.valid || obs.fin || obs.err) begin
            vectors++;
            if ((which == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                miscompares++;
                $display("FAIL unexpected_event dut%0d: got %h, expected no event", which, obs);
            end else begin
                e = (which == 0) ? q0.pop_front() : q1.pop_front();
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL event dut%0d: got %h expected %h", which, obs, e);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        o0 = '{valid: out_valid0, start: out_start0, data: out_valid0 ? out_data0 : 8'h00,
               fin: out_end0, err: sync_err0};
        o1 = '{valid: out_valid1, start: out_start1, data: out_valid1 ? out_data1 : 8'h00,
               fin: out_end1, err: sync_err1};
        mon_evt(0, o0);
        mon_evt(1, o1);
        w0 = {dut0.u_aligner.offset, active0, sync_err0, out_end0, out_start0, out_valid0, out_data0};
        w1 = {dut1.u_aligner.offset, active1, sync_err1, out_end1, out_start1, out_valid1, out_data1};
        while (pq.size() > 0 && pq[0].cyc == cyc) begin
            p = pq.pop_front();
            wsel = (p.dut == 0) ? w0 : w1;
            vectors++;
            if ((wsel & p.mask) !== (p.exp & p.mask)) begin
                miscompares++;
                $display("FAIL %s dut%0d: got %h expected %h (mask %h)",
                         p.name, p.dut, wsel & p.mask, p.exp & p.mask, p.mask);
            end
        end
        if (done) begin
            vectors++;
            if (q0.size() != 0 || q1.size() != 0 || pq.size() != 0) begin
                miscompares++;
                $display("FAIL drain: got %0d/%0d/%0d pending, expected 0/0/0",
                         q0.size(), q1.size(), pq.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
        cyc++;
    end

    initial begin
        rst      = 1'b1;
        hs_valid = 1'b0;
        hs_input = 8'h00;
        settle   = 8'd0;
        synct    = 8'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        probe_both("reset_state", 16'h0000, M_ALL);
        rst = 1'b0;
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);

        // Aligned sync, settle 3.
        settle = 8'd3;
        synct  = 8'd20;
        exp_both(ev_data(1'b1, 8'hA5));
        exp_both(ev_data(1'b0, 8'h3C));
        exp_both(ev_end());
        repeat (4) drive(1'b1, 8'h00);
        drive(1'b1, 8'h1D);
        drive(1'b1, 8'hA5);
        probe_both("aligned_offset0", B_ACT, M_OFF | B_ACT | B_VAL);
        drive(1'b1, 8'h3C);
        probe_both("aligned_first", B_ACT | B_STA | B_VAL | 16'h00A5, M_OUTS);
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        probe_both("aligned_end", B_END, M_CTRL);
        drive(1'b0, 8'h00);

        // Sync straddling bytes at bit offset 3, payload 0x96 then 0x5A.
        settle = 8'd1;
        synct  = 8'd0;
        exp_both(ev_data(1'b1, 8'h96));
        exp_both(ev_data(1'b0, 8'h5A));
        exp_both(ev_end());
        repeat (2) drive(1'b1, 8'h00);
        drive(1'b1, 8'hE8);
        drive(1'b1, 8'hB0);
        probe_both("off3_latch", 16'h6000 | B_ACT, M_OFF | B_ACT);
        drive(1'b1, 8'hD4);
        probe_both("off3_first", B_ACT | B_STA | B_VAL | 16'h0096, M_OUTS);
        drive(1'b1, 8'h02);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);

        // Hunt timeout of 5 with no sync present.
        settle = 8'd0;
        synct  = 8'd5;
        exp_both(ev_err());
        drive(1'b1, 8'h00);
        repeat (4) drive(1'b1, 8'h00);
        probe_both("no_err_early", B_ACT, B_ACT | B_ERR);
        drive(1'b1, 8'h00);
        probe_both("sync_err_at5", B_ACT | B_ERR, M_CTRL);
        drive(1'b1, 8'h00);
        probe_both("err_hold", B_ACT, M_CTRL);
        repeat (3) drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        probe_both("err_exit", 16'h0000, M_CTRL);
        drive(1'b0, 8'h00);

        // Single-bit-error sync 0x1C: only the tolerant instance locks.
        settle = 8'd0;
        synct  = 8'd0;
        q1.push_back(ev_data(1'b1, 8'h42));
        q1.push_back(ev_data(1'b0, 8'h42));
        q1.push_back(ev_end());
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h1C);
        drive(1'b1, 8'h42);
        drive(1'b1, 8'h42);
        drive(1'b1, 8'h42);
        probe(0, "tol0_hunting", B_ACT, M_CTRL);
        probe(1, "tol1_locked", B_ACT | B_VAL | 16'h0042, M_OUTS);
        drive(1'b0, 8'h00);
        probe(0, "tol0_silent_exit", 16'h0000, M_CTRL);
        probe(1, "tol1_end", B_END, M_CTRL);
        drive(1'b0, 8'h00);

        // Burst end after four payload bytes.
        settle = 8'd2;
        exp_both(ev_data(1'b1, 8'h11));
        exp_both(ev_data(1'b0, 8'h22));
        exp_both(ev_data(1'b0, 8'h33));
        exp_both(ev_data(1'b0, 8'h44));
        exp_both(ev_end());
        repeat (3) drive(1'b1, 8'h00);
        drive(1'b1, 8'h1D);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h33);
        drive(1'b1, 8'h44);
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        probe_both("end_pulse", B_END, M_CTRL);
        drive(1'b0, 8'h00);
        probe_both("end_single", 16'h0000, M_CTRL);

        // Reset while streaming, then a burst that must be ignored until LP.
        settle = 8'd0;
        exp_both(ev_data(1'b1, 8'h77));
        exp_both(ev_data(1'b0, 8'h88));
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h1D);
        drive(1'b1, 8'h77);
        drive(1'b1, 8'h88);
        drive(1'b1, 8'h99);
        rst = 1'b1;
        drive(1'b1, 8'h1D);
        rst = 1'b0;
        probe_both("reset_mid", 16'h0000, M_ALL);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h1D);
        drive(1'b1, 8'hAB);
        drive(1'b1, 8'hCD);
        drive(1'b1, 8'hEF);
        probe_both("ignored_after_rst", 16'h0000, M_CTRL);
        drive(1'b0, 8'h00);
        exp_both(ev_data(1'b1, 8'hC3));
        exp_both(ev_data(1'b0, 8'hD4));
        exp_both(ev_end());
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h1D);
        drive(1'b1, 8'hC3);
        drive(1'b1, 8'hD4);
        drive(1'b1, 8'h00);
        drive(1'b0, 8'h00);
        repeat (3) drive(1'b0, 8'h00);
        done = 1'b1;
    end

endmodule
